// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// frame framing bytes and the checksum step.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RESP   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// Serial boot controller: receives a length-prefixed, XOR-checksummed image from
// the UART RX FIFO, writes it to instruction memory and releases the core on ACK.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        r_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_lane;
    logic [23:0]       r_word_lo;
    logic [7:0]        r_csum;
    logic [7:0]        r_resp;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_boot_done;
    logic              r_boot_err;

    logic [15:0]       w_len;
    logic              w_len_bad;
    logic              w_pop;
    logic              w_timeout;
    logic              w_last_byte;
    logic              w_ack;

    assign w_pop       = rd_uart;
    assign w_len       = {r_len_hi, r_data};
    assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > MAX_WORDS);
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYC));
    assign w_last_byte = (r_lane == 2'd3) && ((r_word_cnt + 16'd1) == r_len);
    assign w_ack       = (r_state == CSUM) && w_pop && (r_data == r_csum);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a waiting byte always takes precedence over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_pop && (r_data == SYNC_BYTE)) ? LEN_HI : IDLE;
            LEN_HI:  w_next = w_pop ? LEN_LO : (w_timeout ? RESP : LEN_HI);
            LEN_LO: begin
                if (w_pop) begin
                    w_next = w_len_bad ? RESP : DATA;
                end else begin
                    w_next = w_timeout ? RESP : LEN_LO;
                end
            end
            DATA: begin
                if (w_pop) begin
                    w_next = w_last_byte ? CSUM : DATA;
                end else begin
                    w_next = w_timeout ? RESP : DATA;
                end
            end
            CSUM:    w_next = (w_pop || w_timeout) ? RESP : CSUM;
            RESP: begin
                if (!tx_full) begin
                    w_next = (r_resp == ACK_BYTE) ? DONE : IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // FIFO handshakes; the pop follows the FWFT head combinationally.
    always_comb begin
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        case (r_state)
            IDLE, LEN_HI, LEN_LO, DATA, CSUM: rd_uart = reset & ~rx_empty;
            RESP: begin
                wr_uart = reset & ~tx_full;
                w_data  = (reset & ~tx_full) ? r_resp : 8'h00;
            end
            default: begin
                rd_uart = 1'b0;
                wr_uart = 1'b0;
            end
        endcase
    end

    // Length capture, byte assembly, checksum, memory write and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_hi     <= 8'h00;
            r_len        <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_word_idx   <= '0;
            r_lane       <= 2'd0;
            r_word_lo    <= 24'h000000;
            r_csum       <= 8'h00;
            r_resp       <= 8'h00;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'h0000_0000;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
        end else begin
            r_imem_we   <= 1'b0;
            r_boot_done <= (w_next == DONE);
            if ((w_next == RESP) && (r_state != RESP)) begin
                r_resp <= w_ack ? ACK_BYTE : NAK_BYTE;
            end
            case (r_state)
                IDLE: begin
                    r_word_cnt <= 16'd0;
                    r_word_idx <= '0;
                    r_lane     <= 2'd0;
                    r_csum     <= 8'h00;
                    if (w_pop && (r_data == SYNC_BYTE)) begin
                        r_boot_err <= 1'b0;
                    end
                end
                LEN_HI: if (w_pop) r_len_hi <= r_data;
                LEN_LO: if (w_pop) r_len <= w_len;
                DATA: begin
                    if (w_pop) begin
                        r_csum <= csum_update(r_csum, r_data);
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word_lo[7:0]   <= r_data;
                            2'd1: r_word_lo[15:8]  <= r_data;
                            2'd2: r_word_lo[23:16] <= r_data;
                            default: begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_word_idx;
                                r_imem_wdata <= {r_data, r_word_lo};
                                r_word_idx   <= r_word_idx + ADDR_W'(1);
                                r_word_cnt   <= r_word_cnt + 16'd1;
                            end
                        endcase
                    end
                end
                RESP: begin
                    if (!tx_full && (r_resp != ACK_BYTE)) begin
                        r_boot_err <= 1'b1;
                    end
                end
                default: r_boot_err <= r_boot_err;
            endcase
        end
    end

    // Inter-byte idle counter, live only while a frame is being received.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                LEN_HI, LEN_LO, DATA, CSUM: begin
                    if (w_pop) begin
                        r_to_cnt <= '0;
                    end else if (rx_empty && !w_timeout) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_to_cnt <= '0;
            endcase
        end
    end

    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign boot_done   = r_boot_done;
    assign cpu_reset_n = r_boot_done;
    assign boot_err    = r_boot_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frame table, multi-cycle
// corner sequences, and random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;
    localparam int TO_CYC    = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        r_data = 8'h00;
    logic              rx_empty = 1'b1;
    logic              rd_uart;
    logic              tx_full = 1'b0;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset_n;
    logic              boot_done;
    logic              boot_err;

    always #5 clk = ~clk;

    uart_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .reset(reset), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset_n(cpu_reset_n),
        .boot_done(boot_done), .boot_err(boot_err)
    );

    typedef struct {
        int           nb;
        logic [127:0] bytes;
        logic [7:0]   resp;
        int           nwr;
        logic         done;
        logic         err;
    } vec_t;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [41:0] wq[$];
    logic [41:0] exp_wq[$];
    logic [7:0]  exp_resp;
    bit          gaps = 1'b0;
    bit          pop_pending = 1'b0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[7];

    // Monitor: record pushes/writes and note whether the head gets popped.
    always @(negedge clk) begin
        if (wr_uart) txq.push_back(w_data);
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
        pop_pending = rd_uart;
    end

    // FWFT RX FIFO model, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0) || (gaps && $urandom_range(0, 3) == 0);
        r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: skip to sync, decode, and list expected writes/response.
    function automatic void model(input logic [7:0] b[$]);
        int i = 0;
        int n;
        logic [7:0]  cs = 8'h00;
        logic [31:0] w;
        exp_wq.delete();
        exp_resp = 8'h00;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i >= b.size()) return;
        i++;
        if (i + 2 > b.size()) begin exp_resp = 8'h15; return; end
        n = {b[i], b[i+1]};
        i += 2;
        if (n == 0 || n > MAX_WORDS) begin exp_resp = 8'h15; return; end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > b.size()) begin exp_resp = 8'h15; return; end
            w  = {b[i+3], b[i+2], b[i+1], b[i]};
            cs = cs ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            exp_wq.push_back({10'(k), w});
            i += 4;
        end
        if (i >= b.size()) begin exp_resp = 8'h15; return; end
        exp_resp = (b[i] == cs) ? 8'h06 : 8'h15;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        tx_full = 1'b0;
        rxq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b[$], input int budget);
        int n = 0;
        txq.delete();
        wq.delete();
        foreach (b[k]) rxq.push_back(b[k]);
        while (txq.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] resp_exp, input int nwr_exp,
                                 input logic done_exp, input logic err_exp);
        int m;
        check({tag, " tx count"}, txq.size(), 1);
        check({tag, " tx byte"}, (txq.size() > 0) ? txq[0] : 8'h00, resp_exp);
        check({tag, " write count"}, wq.size(), nwr_exp);
        m = (wq.size() < exp_wq.size()) ? wq.size() : exp_wq.size();
        for (int k = 0; k < m; k++) check($sformatf("%s write %0d", tag, k), wq[k], exp_wq[k]);
        check({tag, " boot_done"}, boot_done, done_exp);
        check({tag, " cpu_reset_n"}, cpu_reset_n, done_exp);
        check({tag, " boot_err"}, boot_err, err_exp);
        check({tag, " rx drained"}, rxq.size(), 0);
    endtask

    function automatic void vec_bytes(input vec_t v, output logic [7:0] q[$]);
        logic [127:0] bb;
        q.delete();
        bb = v.bytes;
        for (int k = 0; k < v.nb; k++) q.push_back(bb[127-8*k -: 8]);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] good[$];
        int n;

        vecs[0] = '{12, 128'hA5000211_22334455_66778888_00000000, 8'h06, 2, 1'b1, 1'b0};
        vecs[1] = '{12, 128'hA5000211_22334455_66778800_00000000, 8'h15, 2, 1'b0, 1'b1};
        vecs[2] = '{15, 128'h00FF5AA5_00021122_33445566_77888800, 8'h06, 2, 1'b1, 1'b0};
        vecs[3] = '{3,  128'hA5000000_00000000_00000000_00000000, 8'h15, 0, 1'b0, 1'b1};
        vecs[4] = '{3,  128'hA5040100_00000000_00000000_00000000, 8'h15, 0, 1'b0, 1'b1};
        vecs[5] = '{8,  128'hA50001DE_ADBEEF22_00000000_00000000, 8'h06, 1, 1'b1, 1'b0};
        vecs[6] = '{8,  128'hA50001A5_A5010203_00000000_00000000, 8'h06, 1, 1'b1, 1'b0};
        vec_bytes(vecs[0], good);

        // Reset values, with a byte waiting so the pop gating is exercised.
        @(negedge clk);
        rxq.push_back(8'h00);
        repeat (3) @(negedge clk);
        check("rst rd_uart", rd_uart, 1'b0);
        check("rst wr_uart", wr_uart, 1'b0);
        check("rst w_data", w_data, 8'h00);
        check("rst imem_we", imem_we, 1'b0);
        check("rst imem_addr", imem_addr, 10'd0);
        check("rst imem_wdata", imem_wdata, 32'd0);
        check("rst cpu_reset_n", cpu_reset_n, 1'b0);
        check("rst boot_done", boot_done, 1'b0);
        check("rst boot_err", boot_err, 1'b0);

        // Directed frame table.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            vec_bytes(vecs[v], q);
            model(q);
            run_frame(q, 400);
            compare_frame($sformatf("vec%0d", v), vecs[v].resp, vecs[v].nwr, vecs[v].done, vecs[v].err);
        end

        // Bad checksum, then retry: sync clears boot_err, image loads, DONE ignores RX.
        do_reset();
        vec_bytes(vecs[1], q);
        run_frame(q, 400);
        check("retry first nak", (txq.size() > 0) ? txq[0] : 8'h00, 8'h15);
        check("retry err set", boot_err, 1'b1);
        txq.delete();
        wq.delete();
        rxq.push_back(8'hA5);
        repeat (4) @(negedge clk);
        check("retry err cleared at sync", boot_err, 1'b0);
        for (int k = 1; k < good.size(); k++) rxq.push_back(good[k]);
        repeat (30) @(negedge clk);
        check("retry word0", (wq.size() > 0) ? wq[0] : 42'd0, {10'd0, 32'h44332211});
        check("retry word1", (wq.size() > 1) ? wq[1] : 42'd0, {10'd1, 32'h88776655});
        check("retry ack", (txq.size() > 0) ? txq[0] : 8'h00, 8'h06);
        check("retry done", boot_done, 1'b1);
        rxq.push_back(8'h5A);
        repeat (10) @(negedge clk);
        check("done leaves rx byte", rxq.size(), 1);
        check("done rd_uart low", rd_uart, 1'b0);

        // Timeout after three data bytes.
        do_reset();
        txq.delete();
        wq.delete();
        foreach (good[k]) if (k < 6) rxq.push_back(good[k]);
        n = 0;
        while (rxq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (txq.size() == 0 && n < 300) begin @(negedge clk); n++; end
        check("timeout latency ok", (n >= 100 && n <= 103), 1'b1);
        check("timeout nak", (txq.size() > 0) ? txq[0] : 8'h00, 8'h15);
        repeat (2) @(negedge clk);
        check("timeout no write", wq.size(), 0);
        check("timeout err", boot_err, 1'b1);
        model(good);
        run_frame(good, 400);
        compare_frame("after timeout", 8'h06, 2, 1'b1, 1'b0);

        // TX backpressure in RESP.
        do_reset();
        tx_full = 1'b1;
        txq.delete();
        foreach (good[k]) rxq.push_back(good[k]);
        repeat (20) @(negedge clk);
        repeat (20) @(negedge clk);
        check("bp no push while full", txq.size(), 0);
        check("bp not done while full", boot_done, 1'b0);
        tx_full = 1'b0;
        repeat (5) @(negedge clk);
        check("bp single push", txq.size(), 1);
        check("bp ack", (txq.size() > 0) ? txq[0] : 8'h00, 8'h06);
        check("bp done", boot_done, 1'b1);

        // Reset in the middle of DATA.
        do_reset();
        wq.delete();
        foreach (good[k]) if (k < 9) rxq.push_back(good[k]);
        n = 0;
        while (wq.size() == 0 && n < 100) begin @(negedge clk); n++; end
        reset = 1'b0;
        rxq.delete();
        @(negedge clk);
        check("mid rst imem_we", imem_we, 1'b0);
        check("mid rst imem_wdata", imem_wdata, 32'd0);
        check("mid rst boot_done", boot_done, 1'b0);
        check("mid rst rd_uart", rd_uart, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model(good);
        run_frame(good, 400);
        compare_frame("after mid rst", 8'h06, 2, 1'b1, 1'b0);

        // Random frames with RX gaps against the reference model.
        gaps = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int nw;
            int ng;
            logic [7:0] cs;
            logic [7:0] bt;
            do_reset();
            q.delete();
            ng = $urandom_range(0, 3);
            for (int k = 0; k < ng; k++) begin
                bt = 8'($urandom_range(0, 255));
                if (bt == 8'hA5) bt = 8'h5A;
                q.push_back(bt);
            end
            nw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            q.push_back(8'hA5);
            q.push_back(8'h00);
            q.push_back(8'(nw));
            cs = 8'h00;
            for (int k = 0; k < 4 * nw; k++) begin
                bt = 8'($urandom_range(0, 255));
                cs = cs ^ bt;
                q.push_back(bt);
            end
            if (nw != 0) q.push_back(($urandom_range(0, 3) == 0) ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
            model(q);
            run_frame(q, 4 * q.size() + 300);
            compare_frame($sformatf("rand%0d", t), exp_resp, exp_wq.size(),
                          exp_resp == 8'h06, exp_resp == 8'h15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial boot controller that sequences the UART receive/transmit FIFOs to load a program image into instruction memory before the RISC-V core runs. It sits between the UART top-level FIFO interface and the instruction-memory write port, and holds the core in reset until a checksummed image is loaded. It answers each frame with ACK or NAK over the UART TX FIFO.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted image in 32-bit words; must be ≤ 2**ADDR_W.
- TIMEOUT_CYC, 1_000_000, idle clock cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- r_data  in  8  RX FIFO head byte; valid whenever rx_empty=0 (first-word fall-through).
- rx_empty  in  1  RX FIFO empty.
- rd_uart  out  1  RX FIFO pop; pops the byte on r_data in that cycle.
- tx_full  in  1  TX FIFO full.
- wr_uart  out  1  TX FIFO push.
- w_data  out  8  TX byte; valid while wr_uart=1.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  write data.
- cpu_reset_n  out  1  core reset; 0 holds the core in reset.
- boot_done  out  1  image loaded and acknowledged.
- boot_err  out  1  last frame NAKed.

## Operation
Frame format:
- 0xA5 sync byte.
- LEN_HI, then LEN_LO: N, the word count, big-endian, 16 bits.
- 4·N data bytes, each word little-endian.
- CSUM = XOR of all data bytes.

States:
- IDLE: pop and discard any byte that is not 0xA5. On 0xA5, clear boot_err and go to LEN_HI.
- LEN_HI, LEN_LO: capture N. After LEN_LO, if N=0 or N>MAX_WORDS, go to RESP with NAK; otherwise go to DATA with word index 0 and csum 0.
- DATA:
  - Each popped byte is XORed into csum and shifted into the word at byte lane (count mod 4).
  - When the 4th byte of a word is popped, the next cycle issues imem_we=1 for one cycle with imem_addr = word index and imem_wdata = the assembled word; the word index then increments.
  - After the 4·N-th byte, go to CSUM.
- CSUM: pop one byte. If it equals the accumulated csum, go to RESP with ACK (0x06); otherwise go to RESP with NAK (0x15).
- RESP:
  - Hold while tx_full=1.
  - When tx_full=0, assert wr_uart for exactly one cycle with the response byte.
  - After ACK, go to DONE. After NAK, set boot_err=1 and go to IDLE.
- DONE: cpu_reset_n=1 and boot_done=1. rd_uart stays 0, so later RX bytes are left to the application. The block stays in DONE until reset.

Timeout:
- In LEN_HI, LEN_LO, DATA or CSUM, a counter counts cycles with rx_empty=1 and clears on every pop.
- When the counter reaches TIMEOUT_CYC, go to RESP with NAK.
- Partially written memory is not rolled back.

## Timing
- Reset values: rd_uart=0, wr_uart=0, w_data=0x00, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, boot_done=0, boot_err=0, state=IDLE, all counters 0.
- rd_uart = (rx_empty=0) and (state is IDLE, LEN_HI, LEN_LO, DATA or CSUM). Back-to-back pops are allowed, one byte per cycle.
- Memory write latency is 1 cycle after the 4th byte's pop. The write for the last word may coincide with the CSUM pop.
- The RESP write happens no earlier than 1 cycle after the CSUM/LEN_LO pop or the timeout.
- cpu_reset_n and boot_done rise in the cycle after wr_uart(ACK). They are registered and glitch-free.
- Widths: word index is ADDR_W bits. The byte counter is 2 bits for the lane plus a 16-bit word counter compared against N.
- Reset asserted mid-frame: all state and outputs take their reset values at the next clk edge. A new frame then loads from address 0.
- A 0xA5 byte inside DATA is ordinary data and is not a resync.

## Structure
- Package uart_boot_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, RESP, DONE);
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15.
- Single module, no sub-module; the FSM, byte assembler, checksum and timeout counter are inline.

## Test plan
- Good frame: A5 00 02 11 22 33 44 55 66 77 88 88.
  - Expect imem writes addr 0 = 0x44332211 and addr 1 = 0x88776655.
  - TX byte 0x06; cpu_reset_n=1 and boot_done=1.
- Bad checksum: same frame with CSUM 0x00.
  - Expect TX 0x15, boot_err=1, cpu_reset_n=0.
  - Retry with the good frame: boot_err clears at the sync byte and the image loads.
- Leading garbage: 00 FF 5A sent before a good frame. Expect the three bytes popped with no writes and no TX; the good frame then loads normally.
- Length check:
  - A5 00 00: NAK and no imem_we.
  - A5 04 01 with MAX_WORDS=1024: NAK right after LEN_LO.
- Timeout: stop after 3 data bytes with TIMEOUT_CYC=100.
  - Expect NAK once the counter reaches 100 idle cycles.
  - No imem_we for the partial word; state returns to IDLE.
- Backpressure and reset:
  - tx_full=1 for 20 cycles in RESP: wr_uart stays 0, then exactly one push.
  - reset=0 mid-DATA: all outputs return to their reset values, and the next frame writes from address 0.
